// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM state and requester ids,
// plus the stats counter width and a saturating increment helper.
package ram_arb_defs;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    localparam int STATS_W = 16;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] cnt,
                                                   input logic               en);
        logic [STATS_W-1:0] res;
        if (en && (cnt != {STATS_W{1'b1}})) begin
            res = cnt + {{(STATS_W-1){1'b0}}, 1'b1};
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone request wins, under contention the requester
// that did not win last time gets the grant. Bit 0 = requester A, bit 1 = requester B.
module rr_arb2
    import ram_arb_defs::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    output logic [1:0] grant
);

    // one-hot grant selection
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == REQ_B) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one sync_ram.
// Optional grant/contention statistics are built when RAM_ARB_STATS_EN is defined.
module ram_arbiter
    import ram_arb_defs::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_resp_valid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_resp_valid,
    output logic [DATA_WIDTH-1:0] b_rdata,
`ifdef RAM_ARB_STATS_EN
    output logic [STATS_W-1:0]    a_grant_cnt,
    output logic [STATS_W-1:0]    b_grant_cnt,
    output logic [STATS_W-1:0]    conflict_cnt,
`endif
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  ram_read,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    state_t                  state_r;
    state_t                  state_next_s;
    req_id_t                 last_grant_r;
    req_id_t                 lat_id_r;
    req_id_t                 win_id_s;
    logic                    lat_we_r;
    logic [ADDR_WIDTH-1:0]   lat_addr_r;
    logic [DATA_WIDTH-1:0]   lat_wdata_r;
    logic [1:0]              grant_s;
    logic                    accept_s;
    logic                    a_resp_valid_r;
    logic                    b_resp_valid_r;
    logic [DATA_WIDTH-1:0]   a_rdata_r;
    logic [DATA_WIDTH-1:0]   b_rdata_r;

    rr_arb2 u_rr_arb2 (
        .valid      ({b_valid, a_valid}),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    assign accept_s = (state_r == IDLE) && (grant_s != 2'b00);
    assign win_id_s = grant_s[1] ? REQ_B : REQ_A;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: any grant moves to a single ACCESS cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = accept_s ? ACCESS : IDLE;
            ACCESS:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE, RAM strobes only in ACCESS
    always_comb begin
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        ram_we   = 1'b0;
        ram_read = 1'b0;
        case (state_r)
            IDLE: begin
                a_ready = grant_s[0];
                b_ready = grant_s[1];
            end
            ACCESS: begin
                ram_we   = lat_we_r;
                ram_read = ~lat_we_r;
            end
            default: begin
                a_ready  = 1'b0;
                b_ready  = 1'b0;
            end
        endcase
    end

    // command latch and round-robin history, loaded on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= REQ_B;
            lat_id_r     <= REQ_A;
            lat_we_r     <= 1'b0;
            lat_addr_r   <= {ADDR_WIDTH{1'b0}};
            lat_wdata_r  <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            last_grant_r <= win_id_s;
            lat_id_r     <= win_id_s;
            lat_we_r     <= grant_s[1] ? b_we    : a_we;
            lat_addr_r   <= grant_s[1] ? b_addr  : a_addr;
            lat_wdata_r  <= grant_s[1] ? b_wdata : a_wdata;
        end
    end

    assign ram_addr = lat_addr_r;
    assign ram_din  = lat_wdata_r;

    // response pulse and read-data capture at the end of ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_resp_valid_r <= 1'b0;
            b_resp_valid_r <= 1'b0;
            a_rdata_r      <= {DATA_WIDTH{1'b0}};
            b_rdata_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            a_resp_valid_r <= (state_r == ACCESS) && (lat_id_r == REQ_A);
            b_resp_valid_r <= (state_r == ACCESS) && (lat_id_r == REQ_B);
            if ((state_r == ACCESS) && !lat_we_r && (lat_id_r == REQ_A)) begin
                a_rdata_r <= ram_dout;
            end
            if ((state_r == ACCESS) && !lat_we_r && (lat_id_r == REQ_B)) begin
                b_rdata_r <= ram_dout;
            end
        end
    end

    assign a_resp_valid = a_resp_valid_r;
    assign b_resp_valid = b_resp_valid_r;
    assign a_rdata      = a_rdata_r;
    assign b_rdata      = b_rdata_r;

`ifdef RAM_ARB_STATS_EN
    logic [STATS_W-1:0] a_grant_cnt_r;
    logic [STATS_W-1:0] b_grant_cnt_r;
    logic [STATS_W-1:0] conflict_cnt_r;

    // saturating grant and contention counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_grant_cnt_r  <= {STATS_W{1'b0}};
            b_grant_cnt_r  <= {STATS_W{1'b0}};
            conflict_cnt_r <= {STATS_W{1'b0}};
        end else begin
            a_grant_cnt_r  <= sat_inc(a_grant_cnt_r, accept_s && (win_id_s == REQ_A));
            b_grant_cnt_r  <= sat_inc(b_grant_cnt_r, accept_s && (win_id_s == REQ_B));
            conflict_cnt_r <= sat_inc(conflict_cnt_r, (state_r == IDLE) && a_valid && b_valid);
        end
    end

    assign a_grant_cnt  = a_grant_cnt_r;
    assign b_grant_cnt  = b_grant_cnt_r;
    assign conflict_cnt = conflict_cnt_r;
`endif

endmodule
